// File: rtl/vvop_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : vvop_pkg
//  Description : Shared types and helpers for the vector-vector operation
//                engine: ALU opcodes, FSM state encoding, request field
//                layout and a request-pack helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package vvop_pkg;

    // ALU opcodes carried in the upper three bits of the start command.
    typedef enum logic [2:0] {
        OP_ADD  = 3'd0,
        OP_SUB  = 3'd1,
        OP_AND  = 3'd2,
        OP_OR   = 3'd3,
        OP_XOR  = 3'd4,
        OP_MINU = 3'd5,
        OP_MAXU = 3'd6,
        OP_RSVD = 3'd7
    } op_e;

    // Engine FSM encoding.
    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_RUN   = 2'd1;
    localparam logic [1:0] c_ST_DRAIN = 2'd2;
    localparam logic [1:0] c_ST_DONE  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = c_ST_IDLE,
        ST_RUN   = c_ST_RUN,
        ST_DRAIN = c_ST_DRAIN,
        ST_DONE  = c_ST_DONE
    } state_e;

    // Request layout, LSB first: rd, wr, data[DATA_W], addr[ADDR_W].
    localparam int RD_BIT     = 0;
    localparam int WR_BIT     = 1;
    localparam int c_DATA_LSB = 2;

    // Wide enough for any address up to 64 bits plus data up to 64 bits;
    // callers truncate the result to their own request width.
    localparam int c_PACK_W = 130;

    // Build a request word. addr and data must be zero-extended by the caller.
    function automatic logic [c_PACK_W-1:0] pack_req(
        input int unsigned data_w,
        input logic [63:0] addr,
        input logic [63:0] data,
        input logic        wr,
        input logic        rd
    );
        logic [c_PACK_W-1:0] v;
        v = c_PACK_W'(addr) << (data_w + 32'd2);
        v = v | (c_PACK_W'(data) << c_DATA_LSB);
        v[WR_BIT] = wr;
        v[RD_BIT] = rd;
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/vvop_engine_alu.sv
`default_nettype none
// ============================================================================
//  Module      : vvop_alu
//  Description : Combinational element-wise ALU. All results wrap modulo
//                2^DATA_W; the reserved opcode behaves as ADD.
//  Ports       : op [2:0]        opcode (vvop_pkg::op_e)
//                a, b [DATA_W]   operands (A element, B element)
//                y    [DATA_W]   result
//  Revision    : 1.0 - initial release
// ============================================================================
module vvop_alu
    import vvop_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [2:0]        op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] y
);

    always_comb begin
        y = a + b;
        case (op_e'(op))
            OP_ADD:  y = a + b;
            OP_SUB:  y = a - b;
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_XOR:  y = a ^ b;
            OP_MINU: y = (a < b) ? a : b;
            OP_MAXU: y = (a > b) ? a : b;
            default: y = a + b;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/vvop_engine.sv
`default_nettype none
// ============================================================================
//  Module      : vvop_engine
//  Description : Streams C[i] = alu(op, A[i], B[i]) for i = 0..len-1.
//                Reads of A and B are issued as joint pairs (bounded by
//                MAX_OUT outstanding), each returned A/B response pair is
//                turned straight into a C write, and the run completes once
//                every C write has been acknowledged.
//  Ports       : clk, rst                  clock, sync active-high reset
//                start/_vld/_rdy           command {op[2:0], len[ADDR_W:0]}
//                req_{A,B,C}/_vld/_rdy     request {addr, data, wr, rd}
//                resp_{A,B,C}/_vld/_rdy    response data
//                done/_vld/_rdy            count of elements written
//  Revision    : 1.0 - initial release
// ============================================================================
module vvop_engine
    import vvop_pkg::*;
#(
    parameter int ADDR_W  = 7,
    parameter int DATA_W  = 32,
    parameter int MAX_OUT = 4
) (
    input  logic                     clk,
    input  logic                     rst,

    input  logic [ADDR_W+3:0]        start,
    input  logic                     start_vld,
    output logic                     start_rdy,

    output logic [ADDR_W+DATA_W+1:0] req_A,
    output logic                     req_A_vld,
    input  logic                     req_A_rdy,
    output logic [ADDR_W+DATA_W+1:0] req_B,
    output logic                     req_B_vld,
    input  logic                     req_B_rdy,
    output logic [ADDR_W+DATA_W+1:0] req_C,
    output logic                     req_C_vld,
    input  logic                     req_C_rdy,

    input  logic [DATA_W-1:0]        resp_A,
    input  logic                     resp_A_vld,
    output logic                     resp_A_rdy,
    input  logic [DATA_W-1:0]        resp_B,
    input  logic                     resp_B_vld,
    output logic                     resp_B_rdy,
    input  logic [DATA_W-1:0]        resp_C,
    input  logic                     resp_C_vld,
    output logic                     resp_C_rdy,

    output logic [ADDR_W:0]          done,
    output logic                     done_vld,
    input  logic                     done_rdy
);

    localparam int               REQ_W     = ADDR_W + DATA_W + 2;
    localparam int               CNT_W     = ADDR_W + 1;
    localparam logic [CNT_W-1:0] c_LEN_MAX = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [3:0]       c_MAX_OUT = 4'(MAX_OUT);

    state_e           r_state;
    logic [2:0]       r_op;
    logic [CNT_W-1:0] r_len;
    logic [CNT_W-1:0] r_rd_idx;
    logic [CNT_W-1:0] r_wr_idx;
    logic [CNT_W-1:0] r_wack_cnt;
    logic [3:0]       r_outstanding;

    logic [2:0]        w_start_op;
    logic [CNT_W-1:0]  w_start_len;
    logic [CNT_W-1:0]  w_len_clamped;
    logic              w_active;
    logic              w_rd_vld;
    logic              w_wr_vld;
    logic              w_rd_fire;
    logic              w_wr_fire;
    logic              w_wack;
    logic [DATA_W-1:0] w_alu_y;
    logic              w_unused;

    assign w_start_op    = start[ADDR_W+3:ADDR_W+1];
    assign w_start_len   = start[ADDR_W:0];
    assign w_len_clamped = (w_start_len > c_LEN_MAX) ? c_LEN_MAX : w_start_len;

    // Everything is gated with rst so the block is silent during reset,
    // regardless of what the state register held before it.
    assign w_active  = !rst && ((r_state == ST_RUN) || (r_state == ST_DRAIN));
    assign start_rdy = !rst && (r_state == ST_IDLE);
    assign done_vld  = !rst && (r_state == ST_DONE);
    assign done      = r_wack_cnt;

    // Pair valid is computed only from local state so that neither channel's
    // valid can depend on the other channel's ready.
    assign w_rd_vld  = !rst && (r_state == ST_RUN) && (r_rd_idx < r_len)
                       && (r_outstanding < c_MAX_OUT);
    assign w_rd_fire = w_rd_vld && req_A_rdy && req_B_rdy;

    assign w_wr_vld  = w_active && resp_A_vld && resp_B_vld;
    assign w_wr_fire = w_wr_vld && req_C_rdy;
    assign w_wack    = w_active && resp_C_vld;

    assign req_A_vld  = w_rd_vld;
    assign req_B_vld  = w_rd_vld;
    assign req_C_vld  = w_wr_vld;
    assign resp_A_rdy = w_wr_fire;
    assign resp_B_rdy = w_wr_fire;
    assign resp_C_rdy = w_active;

    vvop_alu #(
        .DATA_W (DATA_W)
    ) u_alu (
        .op (r_op),
        .a  (resp_A),
        .b  (resp_B),
        .y  (w_alu_y)
    );

    assign req_A = REQ_W'(pack_req(DATA_W, 64'(r_rd_idx[ADDR_W-1:0]),
                                   64'd0, 1'b0, 1'b1));
    assign req_B = req_A;
    assign req_C = REQ_W'(pack_req(DATA_W, 64'(r_wr_idx[ADDR_W-1:0]),
                                   64'(w_alu_y), 1'b1, 1'b0));

    // Write acknowledge data carries no information; wr_idx MSB only
    // matters as a counter carry.
    assign w_unused = ^{resp_C, r_wr_idx[ADDR_W]};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_op          <= '0;
            r_len         <= '0;
            r_rd_idx      <= '0;
            r_wr_idx      <= '0;
            r_wack_cnt    <= '0;
            r_outstanding <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start_vld) begin
                        r_op          <= w_start_op;
                        r_len         <= w_len_clamped;
                        r_rd_idx      <= '0;
                        r_wr_idx      <= '0;
                        r_wack_cnt    <= '0;
                        r_outstanding <= '0;
                        r_state       <= (w_start_len == '0) ? ST_DONE : ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (r_rd_idx == r_len) begin
                        r_state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (r_wack_cnt == r_len) begin
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (done_rdy) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase

            // Fires are only possible in RUN/DRAIN, so these never collide
            // with the counter clear on a start transfer.
            if (w_rd_fire) begin
                r_rd_idx <= r_rd_idx + CNT_W'(1);
            end
            if (w_wr_fire) begin
                r_wr_idx <= r_wr_idx + CNT_W'(1);
            end
            if (w_wack) begin
                r_wack_cnt <= r_wack_cnt + CNT_W'(1);
            end

            // Simultaneous issue and retire cancel out.
            case ({w_rd_fire, w_wr_fire})
                2'b10:   r_outstanding <= r_outstanding + 4'd1;
                2'b01:   r_outstanding <= r_outstanding - 4'd1;
                default: r_outstanding <= r_outstanding;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_vvop_engine.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vvop_engine
//  Description : Directed self-checking bench for vvop_engine with a
//                behavioural A/B/C memory model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_vvop_engine;
    import vvop_pkg::*;

    localparam int ADDR_W  = 4;
    localparam int DATA_W  = 32;
    localparam int MAX_OUT = 2;
    localparam int REQ_W   = ADDR_W + DATA_W + 2;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic [ADDR_W+3:0] start     = '0;
    logic              start_vld = 1'b0;
    logic              start_rdy;
    logic [REQ_W-1:0]  req_A, req_B, req_C;
    logic              req_A_vld, req_B_vld, req_C_vld;
    logic              req_A_rdy = 1'b0, req_B_rdy = 1'b0, req_C_rdy = 1'b0;
    logic [DATA_W-1:0] resp_A = '0, resp_B = '0, resp_C = '0;
    logic              resp_A_vld = 1'b0, resp_B_vld = 1'b0, resp_C_vld = 1'b0;
    logic              resp_A_rdy, resp_B_rdy, resp_C_rdy;
    logic [ADDR_W:0]   done;
    logic              done_vld;
    logic              done_rdy = 1'b1;

    vvop_engine #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .MAX_OUT (MAX_OUT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .start_vld  (start_vld),
        .start_rdy  (start_rdy),
        .req_A      (req_A),
        .req_A_vld  (req_A_vld),
        .req_A_rdy  (req_A_rdy),
        .req_B      (req_B),
        .req_B_vld  (req_B_vld),
        .req_B_rdy  (req_B_rdy),
        .req_C      (req_C),
        .req_C_vld  (req_C_vld),
        .req_C_rdy  (req_C_rdy),
        .resp_A     (resp_A),
        .resp_A_vld (resp_A_vld),
        .resp_A_rdy (resp_A_rdy),
        .resp_B     (resp_B),
        .resp_B_vld (resp_B_vld),
        .resp_B_rdy (resp_B_rdy),
        .resp_C     (resp_C),
        .resp_C_vld (resp_C_vld),
        .resp_C_rdy (resp_C_rdy),
        .done       (done),
        .done_vld   (done_vld),
        .done_rdy   (done_rdy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [ADDR_W-1:0] f_addr(input logic [REQ_W-1:0] r);
        return r[REQ_W-1:DATA_W+2];
    endfunction

    function automatic logic [DATA_W-1:0] f_data(input logic [REQ_W-1:0] r);
        return r[DATA_W+1:2];
    endfunction

    // ------------------------------------------------------------------
    // Memory model: drives inputs at negedge+1, samples handshakes at
    // negedge+3 (just before the active edge). Directed steps run at +2.
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] mem_a [16];
    logic [DATA_W-1:0] mem_b [16];
    logic [DATA_W-1:0] qa[$];
    logic [DATA_W-1:0] qb[$];
    int                qc = 0;
    bit                ab_rdy_en  = 1'b1;
    bit                ab_resp_en = 1'b1;
    bit                c_rdy_en   = 1'b1;
    logic [ADDR_W-1:0] wlog_addr[$];
    logic [DATA_W-1:0] wlog_data[$];
    int                rd_cnt = 0, respc_cnt = 0, done_cnt = 0;
    int                respc_at_done = 0, proto_err = 0;
    logic [ADDR_W:0]   last_done = '0;

    always begin
        @(negedge clk);
        #1;
        req_A_rdy  = ab_rdy_en;
        req_B_rdy  = ab_rdy_en;
        req_C_rdy  = c_rdy_en;
        resp_A_vld = ab_resp_en && (qa.size() > 0);
        resp_A     = (qa.size() > 0) ? qa[0] : '0;
        resp_B_vld = ab_resp_en && (qb.size() > 0);
        resp_B     = (qb.size() > 0) ? qb[0] : '0;
        resp_C_vld = (qc > 0);
        resp_C     = 32'hDEAD_BEEF;
        #2;
        if (rst) begin
            qa.delete();
            qb.delete();
            qc = 0;
        end else begin
            if (resp_A_vld && resp_A_rdy) void'(qa.pop_front());
            if (resp_B_vld && resp_B_rdy) void'(qb.pop_front());
            if (req_A_vld && req_A_rdy) begin
                if (req_A[RD_BIT] !== 1'b1 || req_A[WR_BIT] !== 1'b0 ||
                    f_addr(req_A) !== rd_cnt[ADDR_W-1:0] || f_data(req_A) !== '0)
                    proto_err++;
                qa.push_back(mem_a[f_addr(req_A)]);
                rd_cnt++;
            end
            if (req_B_vld && req_B_rdy) begin
                if (req_B !== req_A) proto_err++;
                qb.push_back(mem_b[f_addr(req_B)]);
            end
            if (req_C_vld && req_C_rdy) begin
                if (req_C[WR_BIT] !== 1'b1 || req_C[RD_BIT] !== 1'b0) proto_err++;
                wlog_addr.push_back(f_addr(req_C));
                wlog_data.push_back(f_data(req_C));
                qc++;
            end
            if (resp_C_vld && resp_C_rdy) begin
                qc--;
                respc_cnt++;
            end
            if (done_vld && done_rdy) begin
                done_cnt++;
                last_done     = done;
                respc_at_done = respc_cnt;
            end
        end
    end

    // ------------------------------------------------------------------
    // Directed sequence helpers
    // ------------------------------------------------------------------
    task automatic step();
        @(negedge clk);
        #2;
    endtask

    task automatic clear_logs();
        wlog_addr.delete();
        wlog_data.delete();
        rd_cnt = 0; respc_cnt = 0; done_cnt = 0; respc_at_done = 0;
    endtask

    task automatic start_cmd(input logic [2:0] op, input logic [ADDR_W:0] len);
        clear_logs();
        start     = {op, len};
        start_vld = 1'b1;
        step();
        start_vld = 1'b0;
        start     = '0;
    endtask

    task automatic wait_done(input string tag, input int budget, output int cycles);
        int n;
        n = 0;
        while (done_cnt == 0 && n < budget) begin
            step();
            n++;
        end
        cycles = n;
        chk({tag, "_done_seen"}, 64'(done_cnt > 0), 64'd1);
    endtask

    logic [2:0]        alu_op [7] = '{3'd1, 3'd5, 3'd6, 3'd2, 3'd3, 3'd4, 3'd7};
    logic [DATA_W-1:0] alu_a  [7] = '{32'h0, 32'h5, 32'h5, 32'hF0F0_1234,
                                      32'hF0F0_1234, 32'hF0F0_1234, 32'hFFFF_FFFF};
    logic [DATA_W-1:0] alu_b  [7] = '{32'h1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0FF0_FF00,
                                      32'h0FF0_FF00, 32'h0FF0_FF00, 32'h2};
    logic [DATA_W-1:0] alu_y  [7] = '{32'hFFFF_FFFF, 32'h5, 32'hFFFF_FFFF, 32'h00F0_1200,
                                      32'hFFF0_FF34, 32'hFF00_ED34, 32'h1};

    int                cyc;
    logic [REQ_W-1:0]  snap;

    initial begin
        // Reset state
        step();
        chk("rst_start_rdy", 64'(start_rdy), 0);
        chk("rst_req_A_vld", 64'(req_A_vld), 0);
        chk("rst_req_C_vld", 64'(req_C_vld), 0);
        chk("rst_done_vld",  64'(done_vld), 0);
        chk("rst_resp_A_rdy", 64'(resp_A_rdy), 0);
        chk("rst_resp_C_rdy", 64'(resp_C_rdy), 0);
        rst = 1'b0;
        step();
        chk("idle_start_rdy", 64'(start_rdy), 1);
        chk("idle_req_B_vld", 64'(req_B_vld), 0);

        // ADD, len 4
        for (int i = 0; i < 16; i++) begin
            mem_a[i] = DATA_W'(i + 1);
            mem_b[i] = DATA_W'(10 * (i + 1));
        end
        start_cmd(3'd0, 5'd4);
        wait_done("add4", 40, cyc);
        repeat (3) step();
        chk("add4_nwr", 64'(wlog_addr.size()), 4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("add4_addr%0d", i), 64'(wlog_addr[i]), 64'(i));
            chk($sformatf("add4_data%0d", i), 64'(wlog_data[i]), 64'(11 * (i + 1)));
        end
        chk("add4_done_val", 64'(last_done), 4);
        chk("add4_done_once", 64'(done_cnt), 1);
        chk("add4_respc_before_done", 64'(respc_at_done), 4);

        // len 0 goes straight to DONE
        start_cmd(3'd0, 5'd0);
        chk("len0_done_vld", 64'(done_vld), 1);
        chk("len0_done_val", 64'(done), 0);
        chk("len0_req_A_vld", 64'(req_A_vld), 0);
        step();
        chk("len0_no_reads", 64'(rd_cnt), 0);
        chk("len0_no_writes", 64'(wlog_addr.size()), 0);

        // len clamp (20 -> 16) and full throughput
        start_cmd(3'd0, 5'd20);
        wait_done("clamp", 60, cyc);
        chk("clamp_nwr", 64'(wlog_addr.size()), 16);
        chk("clamp_reads", 64'(rd_cnt), 16);
        chk("clamp_last_addr", 64'((wlog_addr.size() == 16) ? wlog_addr[15] : 'x), 15);
        chk("clamp_last_data", 64'((wlog_data.size() == 16) ? wlog_data[15] : 'x), 176);
        chk("clamp_done_val", 64'(last_done), 16);
        chk("clamp_throughput", 64'(cyc <= 22), 1);
        step();

        // ALU op table, one element each
        for (int t = 0; t < 7; t++) begin
            mem_a[0] = alu_a[t];
            mem_b[0] = alu_b[t];
            start_cmd(alu_op[t], 5'd1);
            wait_done($sformatf("alu%0d", t), 30, cyc);
            chk($sformatf("alu%0d_y", t),
                64'((wlog_data.size() > 0) ? wlog_data[0] : 'x), 64'(alu_y[t]));
            step();
        end

        // Outstanding limit with responses withheld
        for (int i = 0; i < 16; i++) begin
            mem_a[i] = DATA_W'(100 + i);
            mem_b[i] = DATA_W'(i);
        end
        ab_resp_en = 1'b0;
        start_cmd(3'd0, 5'd8);
        repeat (10) step();
        chk("maxout_reads", 64'(rd_cnt), 2);
        chk("maxout_req_A_vld", 64'(req_A_vld), 0);
        chk("maxout_no_writes", 64'(wlog_addr.size()), 0);
        ab_resp_en = 1'b1;
        wait_done("maxout", 60, cyc);
        chk("maxout_nwr", 64'(wlog_addr.size()), 8);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("maxout_addr%0d", i), 64'(wlog_addr[i]), 64'(i));
        end
        chk("maxout_done_val", 64'(last_done), 8);
        step();

        // req_C stall mid-vector, plus a start that must be ignored
        start_cmd(3'd0, 5'd8);
        repeat (3) step();
        c_rdy_en  = 1'b0;
        start     = {3'd1, 5'd3};
        start_vld = 1'b1;
        step();
        start_vld = 1'b0;
        start     = '0;
        snap = req_C;
        chk("stall_req_C_vld", 64'(req_C_vld), 1);
        chk("stall_resp_A_rdy0", 64'(resp_A_rdy), 0);
        for (int k = 1; k < 5; k++) begin
            step();
            chk($sformatf("stall_payload%0d", k), 64'(req_C == snap), 1);
            chk($sformatf("stall_resp_B_rdy%0d", k), 64'(resp_B_rdy), 0);
        end
        c_rdy_en = 1'b1;
        wait_done("stall", 60, cyc);
        chk("stall_nwr", 64'(wlog_addr.size()), 8);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("stall_addr%0d", i), 64'(wlog_addr[i]), 64'(i));
            chk($sformatf("stall_data%0d", i), 64'(wlog_data[i]), 64'(100 + 2 * i));
        end
        chk("stall_done_val", 64'(last_done), 8);
        step();

        // Reset after 3 of 8 elements, then a fresh len 2 run
        for (int i = 0; i < 16; i++) begin
            mem_a[i] = DATA_W'(i);
            mem_b[i] = DATA_W'(i);
        end
        start_cmd(3'd0, 5'd8);
        cyc = 0;
        while (wlog_addr.size() < 3 && cyc < 30) begin
            step();
            cyc++;
        end
        chk("rstmid_reached3", 64'(wlog_addr.size() >= 3), 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        chk("rstmid_start_rdy", 64'(start_rdy), 1);
        chk("rstmid_req_A_vld", 64'(req_A_vld), 0);
        chk("rstmid_req_C_vld", 64'(req_C_vld), 0);
        chk("rstmid_done_vld", 64'(done_vld), 0);
        chk("rstmid_nwr", 64'(wlog_addr.size()), 3);
        start_cmd(3'd0, 5'd2);
        wait_done("post_rst", 30, cyc);
        chk("post_rst_nwr", 64'(wlog_addr.size()), 2);
        chk("post_rst_data1", 64'((wlog_data.size() > 1) ? wlog_data[1] : 'x), 2);
        chk("post_rst_done_val", 64'(last_done), 2);

        step();
        chk("protocol_errors", 64'(proto_err), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/vvop_engine.md
VVOP_ENGINE -- requirements
Module: vvop_engine

Interface
REQ-001 Parameter ADDR_W, default 7: element address width; max vector length 2^ADDR_W.
REQ-002 Parameter DATA_W, default 32: element data width.
REQ-003 Parameter MAX_OUT, default 4: max outstanding A/B read pairs, range 1..15.
REQ-004 clk  in  1  clock; reset rst, synchronous, active-high; clock clk.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 start  in  ADDR_W+4  command {op[2:0], len[ADDR_W:0]}; start_vld in 1; start_rdy out 1.
REQ-007 req_A, req_B, req_C  out  ADDR_W+DATA_W+2  request {addr, data, wr, rd}; each has _vld out 1 and _rdy in 1.
REQ-008 resp_A, resp_B, resp_C  in  DATA_W  response data; each has _vld in 1 and _rdy out 1.
REQ-009 done  out  ADDR_W+1  count of elements written; done_vld out 1; done_rdy in 1.

Function
REQ-010 Every channel SHALL transfer on a cycle where _vld & _rdy; a raised _vld SHALL hold with stable payload until transfer.
REQ-011 FSM states SHALL be IDLE, RUN, DRAIN, DONE; start_rdy = 1 only in IDLE.
REQ-012 On a start transfer, op and len SHALL be latched; len > 2^ADDR_W SHALL clamp to 2^ADDR_W; len = 0 SHALL go straight to DONE with done = 0.
REQ-013 In RUN, req_A and req_B SHALL be issued jointly: both _vld = 1 only when rd_idx < len and outstanding < MAX_OUT.
REQ-014 A read pair SHALL advance (rd_idx+1, outstanding+1) only in a cycle where req_A_rdy & req_B_rdy; neither _vld SHALL depend on the other channel's _rdy.
REQ-015 Read requests SHALL carry {rd_idx, 0, wr=0, rd=1}, addresses 0..len-1 in order.
REQ-016 req_C_vld SHALL equal resp_A_vld & resp_B_vld in RUN/DRAIN, with payload {wr_idx, alu(op, resp_A, resp_B), wr=1, rd=0}.
REQ-017 resp_A_rdy = resp_B_rdy = req_C transfer; on that transfer wr_idx+1 and outstanding-1.
REQ-018 Simultaneous read-pair issue and write issue SHALL leave outstanding unchanged.
REQ-019 resp_C_rdy SHALL be 1 in RUN/DRAIN; each resp_C transfer SHALL increment wack_cnt; resp_C data SHALL be ignored.
REQ-020 RUN->DRAIN when rd_idx = len; DRAIN->DONE when wack_cnt = len.
REQ-021 In DONE, done_vld = 1 and done = wack_cnt; DONE->IDLE on the done transfer; a start transfer is accepted no earlier than the following cycle.
REQ-022 ALU ops: 0 ADD, 1 SUB (A-B), 2 AND, 3 OR, 4 XOR, 5 MINU, 6 MAXU, 7 reserved and treated as ADD; all results modulo 2^DATA_W.
REQ-023 Full throughput SHALL be one element per cycle when all _rdy/_vld are 1 and MAX_OUT >= 2.
REQ-024 start_vld outside IDLE SHALL be ignored, with no effect on the running operation.

Reset
REQ-025 Under rst: state = IDLE and rd_idx, wr_idx, wack_cnt, outstanding, op, len = 0.
REQ-026 Under rst: all _vld outputs and resp_*_rdy = 0; start_rdy = 0 during rst and 1 from the first cycle after.
REQ-027 Reset mid-operation SHALL abandon the vector with no further requests; the memory side is reset together with this block.

Structure
REQ-028 Package vvop_pkg SHALL hold: op enum, FSM state enum, request field offsets (RD_BIT = 0, WR_BIT = 1), and a request-pack function.
REQ-029 A combinational sub-module vvop_alu (op, a, b -> y) SHALL implement REQ-022; counters, FSM and handshakes stay in vvop_engine.

Verification
REQ-030 ADD, len = 4, A = {1,2,3,4}, B = {10,20,30,40}, all channels ready -> C writes at addr 0..3 with {11,22,33,44}; done = 4 once, after the 4th resp_C.
REQ-031 len = 0 -> no req_* valid; done_vld the cycle after start; done = 0.
REQ-032 SUB, A = 0, B = 1 -> C data = 2^DATA_W-1; MINU/MAXU of 5 and 0xFFFFFFFF -> 5 and 0xFFFFFFFF.
REQ-033 MAX_OUT = 2, resp_A/B held invalid, len = 8 -> exactly 2 read pairs issued, then req_A_vld = 0 until a C write; wr_idx sequence stays 0..7.
REQ-034 req_C_rdy low for 5 cycles mid-vector -> req_C payload stable, resp_A/B_rdy = 0; no element lost or duplicated.
REQ-035 rst asserted after 3 of 8 elements -> next cycle all _vld = 0 and start_rdy = 1; a new len = 2 run completes with done = 2.
